// File: rtl/data_memory_io.sv
// Data RAM for the MIPS max/min system with a memory-mapped 4-digit
// seven-segment display (max/min digits) and up/down mode buttons.
module data_memory_io #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 6,
  parameter int SCAN_BITS  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  output logic [3:0]       AN,
  output logic [7:0]       CX
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      ram [DEPTH];
  logic [DEPTH_BITS-1:0] idx;
  logic                  adr_unused;

  logic                  up_p0, up_p1, down_p0, down_p1;
  logic                  mode;
  logic [SCAN_BITS-1:0]  scan_cnt;
  logic [1:0]            sel;
  logic [DEPTH_BITS-1:0] digit_idx;
  logic [3:0]            nibble;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Byte address -> word index; low byte-lane bits and high bits alias away.
  assign idx        = adr[DEPTH_BITS+1:2];
  assign adr_unused = ^{adr[WIDTH-1:DEPTH_BITS+2], adr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (memwrite) begin
      ram[idx] <= writedata;
    end
  end

  assign memdata = ram[idx];

  // Button synchronizers (_p0, _p1) feeding the mode register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_p0    <= 1'b0;
      up_p1    <= 1'b0;
      down_p0  <= 1'b0;
      down_p1  <= 1'b0;
      mode     <= 1'b0;
      scan_cnt <= '0;
    end else begin
      up_p0    <= up;
      up_p1    <= up_p0;
      down_p0  <= down;
      down_p1  <= down_p0;
      scan_cnt <= scan_cnt + 1'b1;
      if (up_p1 && !down_p1)
        mode <= 1'b0;
      else if (down_p1 && !up_p1)
        mode <= 1'b1;
    end
  end

  assign sel = scan_cnt[SCAN_BITS-1 -: 2];

  // Digit words are the top 8 RAM words: {mode, digit} picks one of them.
  assign digit_idx = {{(DEPTH_BITS-3){1'b1}}, mode, sel};
  assign nibble    = ram[digit_idx][3:0];

  always_comb begin
    AN = 4'b1111;
    case (sel)
      2'd0: AN = 4'b1110;
      2'd1: AN = 4'b1101;
      2'd2: AN = 4'b1011;
      2'd3: AN = 4'b0111;
      default: AN = 4'b1111;
    endcase
  end

  assign CX = seg_decode(nibble);

endmodule

// File: tb/tb_data_memory_io.sv
// Randomized scoreboard bench for data_memory_io with a small SCAN_BITS so
// full display scans fit in a few cycles.
module tb_data_memory_io;

  localparam int SB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        up = 1'b0, down = 1'b0, memwrite = 1'b0;
  logic [31:0] adr = '0, writedata = '0;
  logic [31:0] memdata;
  logic [3:0]  AN;
  logic [7:0]  CX;

  data_memory_io #(.WIDTH(32), .DEPTH_BITS(6), .SCAN_BITS(SB)) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata), .AN(AN), .CX(CX)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] md;
    logic [3:0]  an;
    logic [7:0]  cx;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_n = 0;

  // Reference model state
  logic [31:0] m_ram [64];
  int          m_mode;
  int          m_cnt;
  logic [1:0]  m_btn[$];
  logic [7:0]  lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  logic        c_rst = 1'b0, c_up = 1'b0, c_down = 1'b0, c_we = 1'b0;
  logic [31:0] c_adr = '0, c_wd = '0;

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_ram[i] = '0;
    m_mode = 0;
    m_cnt  = 0;
    m_btn  = {2'b00, 2'b00};
  endtask

  // Mode follows the button levels seen two edges earlier.
  task automatic model_edge();
    logic [1:0] b;
    if (!c_rst) return;
    if (c_we) m_ram[c_adr[7:2]] = c_wd;
    m_cnt = (m_cnt + 1) % (1 << SB);
    b = m_btn.pop_front();
    if (b == 2'b10) m_mode = 0;
    else if (b == 2'b01) m_mode = 1;
    m_btn.push_back({c_up, c_down});
  endtask

  task automatic cyc(input logic r, input logic u, input logic d,
                     input logic we, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   sel;
    @(posedge clk);
    model_edge();
    #1;
    reset = r; up = u; down = d; memwrite = we; adr = a; writedata = wd;
    c_rst = r; c_up = u; c_down = d; c_we = we; c_adr = a; c_wd = wd;
    if (!r) model_clear();
    cyc_n++;
    sel  = m_cnt >> (SB - 2);
    e.cyc = cyc_n;
    e.md  = m_ram[a[7:2]];
    e.an  = ~(4'b0001 << sel);
    e.cx  = lut[m_ram[56 + m_mode * 4 + sel][3:0]];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, up, down, 1'b0, adr, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    cyc(1'b1, up, down, 1'b1, a, wd);
  endtask

  // Monitor: compares the DUT against whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec += 3;
      if (memdata !== e.md) begin
        n_err++;
        $display("FAIL memdata cyc=%0d adr=%h got=%h exp=%h", e.cyc, adr, memdata, e.md);
      end
      if (AN !== e.an) begin
        n_err++;
        $display("FAIL AN cyc=%0d got=%b exp=%b", e.cyc, AN, e.an);
      end
      if (CX !== e.cx) begin
        n_err++;
        $display("FAIL CX cyc=%0d got=%h exp=%h", e.cyc, CX, e.cx);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          guard;
    model_clear();
    #1 reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'hE0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // RAM access, aliasing, write-disabled store
    wr(32'h10, 32'h12345678);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h110, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);

    // MAX digits then a full scan
    wr(32'hE0, 32'd7); wr(32'hE4, 32'd4); wr(32'hE8, 32'd3); wr(32'hEC, 32'd1);
    idle(16);

    // MIN digits, mode select, both buttons held
    wr(32'hF0, 32'd2); wr(32'hF4, 32'd0); wr(32'hF8, 32'd9); wr(32'hFC, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(16);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(8);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(16);

    // Blank digit, then live update while the ones digit is lit
    wr(32'hE0, 32'hC);
    idle(16);
    guard = 0;
    while (m_cnt != 0 && guard < 32) begin
      idle(1);
      guard++;
    end
    wr(32'hE0, 32'd5);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic u, d;
      a = $urandom;
      a[7:2] = ($urandom_range(0, 1) == 1) ? 6'(56 + $urandom_range(0, 7))
                                            : 6'($urandom_range(0, 63));
      u = (($urandom_range(0, 15)) == 0) ? ~up : up;
      d = (($urandom_range(0, 15)) == 0) ? ~down : down;
      cyc(1'b1, u, d, 1'($urandom_range(0, 1)), a,
          ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom);
    end

    // Mid-run reset with a write attempt, then restart
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hE0, 32'd8);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'hE0, 32'h0);
    idle(20);

    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_checks got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_io.md
# data_memory_io

Word-addressed data RAM with memory-mapped seven-segment display output and two push-button inputs, serving as the data-side memory of the single-clock MIPS max/min system. The CPU stores values and the computed maximum/minimum as decimal digits into fixed RAM words. This block continuously scans those digits onto a 4-digit common-anode display. Buttons `up`/`down` select whether the maximum or the minimum is shown.

## Interface
- `WIDTH`, 32, data word width.
- `DEPTH_BITS`, 6, log2 of RAM depth in words (64 words).
- `SCAN_BITS`, 16, width of the display refresh counter.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `up` in 1: button; selects MAX display mode.
- `down` in 1: button; selects MIN display mode.
- `memwrite` in 1: write enable from CPU.
- `adr` in WIDTH: byte address from CPU.
- `writedata` in WIDTH: store data.
- `memdata` out WIDTH: load data.
- `AN` out 4: digit enables, active-low, one-hot.
- `CX` out 8: segments, active-low, `{dp,g,f,e,d,c,b,a}`.

## Operation
- Word index = `adr[DEPTH_BITS+1:2]`.
  - `adr[1:0]` is ignored.
  - Bits above `DEPTH_BITS+1` are ignored, so addresses alias.
- Read is combinational: `memdata = RAM[index]`.
- Write: on a rising `clk` edge with `memwrite=1`, `RAM[index] <= writedata`.
- Digit words occupy the top 8 RAM words (values below are for DEPTH_BITS=6):
  - MAX_ONES 56 (0xE0), MAX_TENS 57 (0xE4), MAX_HUNDS 58 (0xE8), MAX_THOUDS 59 (0xEC).
  - MIN_ONES 60 (0xF0), MIN_TENS 61 (0xF4), MIN_HUNDS 62 (0xF8), MIN_THOUDS 63 (0xFC).
- These digit words are ordinary RAM: the CPU can read and write them.
- Mode register: 0 = MAX, 1 = MIN.
  - Synchronized `up`=1 and `down`=0 → mode 0.
  - `down`=1 and `up`=0 → mode 1.
  - Both or neither asserted → mode holds.
  - Buttons are level-sensitive; no debounce beyond synchronization.
- Scan counter: `SCAN_BITS` wide, increments every clock and wraps. Digit select = counter top 2 bits:
  - 0: ones, `AN=1110`
  - 1: tens, `AN=1101`
  - 2: hundreds, `AN=1011`
  - 3: thousands, `AN=0111`
- Displayed nibble = low 4 bits of the selected digit word of the current mode.
- Segment decode gives `CX[6:0]`; `CX[7]` (dp) is always 1.
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90.
  - Nibble 10–15 → FF (blank).
- `AN` and `CX` are combinational from the counter, mode and RAM. A digit-word write is visible immediately after the write edge.

## Timing
- Reset (`reset`=0), asynchronous:
  - All RAM words cleared to 0.
  - Mode = MAX.
  - Scan counter = 0.
  - Button synchronizers cleared.
  - Outputs then: `AN=1110`, `CX=C0`, `memdata=0`.
- Reset mid-operation clears the above immediately. No write occurs while `reset`=0.
- Write latency: 1 edge. A read of the same index in the same cycle returns the old value before the edge and the new value after it.
- Buttons pass through a 2-flop synchronizer feeding the mode register. The mode changes at the 3rd rising edge after the button is sampled high.
- Digit advance: every 2^(SCAN_BITS-2) clocks. Full scan period: 2^SCAN_BITS clocks.

## Test plan
- Reset: assert `reset`=0 mid-run after writes → `memdata=0` at any `adr`, `AN=1110`, `CX=C0` immediately; after release, counter restarts from 0.
- RAM access:
  - Write 0x12345678 to 0x10 → read 0x10 returns 0x12345678.
  - Read 0x110 (alias) returns the same value.
  - `adr=0x13` returns it too.
  - With `memwrite=0`, a store leaves contents unchanged.
- MAX display: write 7, 4, 3, 1 to 0xE0/0xE4/0xE8/0xEC (SCAN_BITS=4) → over 16 clocks `AN`/`CX` cycle 1110/F8, 1101/99, 1011/B0, 0111/F9.
- MIN display and mode select: write 2, 0, 9, 0 to 0xF0–0xFC; hold `down`=1 for 3 clocks.
  - Ones digit shows A4, hundreds shows 90.
  - Then `up`=1 returns to the MAX digits after 3 edges.
  - `up`=`down`=1 keeps the current mode.
- Blank and dp: write 0xC to MAX_ONES → `CX=FF` on that digit; `CX[7]=1` on every digit throughout.
- Live update: while the ones digit is active, write 5 to 0xE0 → `CX` changes from its previous value to 92 right after the write edge.
